// File: rtl/chroma_lock_controller.sv
// chroma_lock_controller: sequences the chroma subcarrier PLL by gating the burst into the
// loop filter, grading each burst, and running the SEARCH/ACQUIRE/LOCKED/HOLDOVER lock FSM.
// Latency: loop_enable opens GUARD_START+1 cycles after a burst rise. A falling burst edge in
// cycle N updates lock_state/locked/color_kill at the edge that ends cycle N+1.
// Backpressure: none. Every input is consumed each cycle and the block never stalls upstream.
//
// Ports:
//   clk            pixel clock (74.25 MHz); the block has a single clock domain
//   rst            asynchronous reset, active low
//   burst_active   burst flag from the sync separator
//   error_in       signed 12-bit burst phase error from the demodulator
//   loop_enable    gate to the loop filter's burst input; forced low in HOLDOVER
//   loop_reset     one-cycle pulse in the first cycle of SEARCH; clears the loop integrator
//   locked         high only in LOCKED
//   color_kill     low only in LOCKED and HOLDOVER; zeroes U/V downstream
//   lock_state     0 SEARCH, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER
// Optional build macro CHROMA_LOCK_STATS_EN adds the following outputs:
//   good_bursts, bad_bursts   saturating totals of graded bursts
//   last_err_sum              error sum captured at the most recent evaluation
module chroma_lock_controller #(
  parameter int GUARD_START  = 16,
  parameter int GATE_LEN     = 128,
  parameter int ERR_THRESH   = 256,
  parameter int LOCK_LINES   = 16,
  parameter int UNLOCK_LINES = 4,
  parameter int LINE_TIMEOUT = 5000,
  parameter int HOLD_LINES   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_active,
  input  logic signed [11:0] error_in,
  output logic              loop_enable,
  output logic              loop_reset,
  output logic              locked,
  output logic              color_kill,
  output logic [1:0]        lock_state
`ifdef CHROMA_LOCK_STATS_EN
  ,
  output logic [15:0]       good_bursts,
  output logic [15:0]       bad_bursts,
  output logic [19:0]       last_err_sum
`endif
);

  localparam int GDW = $clog2(GUARD_START + 1);
  localparam int GTW = $clog2(GATE_LEN + 1);
  localparam int WDW = $clog2(LINE_TIMEOUT);
  localparam int MW  = $clog2(HOLD_LINES + 1);

  localparam logic [GDW-1:0] GUARD_LAST = GDW'(GUARD_START);
  localparam logic [GTW-1:0] GATE_LAST  = GTW'(GATE_LEN);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(LINE_TIMEOUT - 1);
  // Mean-error threshold folded into a sum threshold so no divider is needed.
  localparam logic [19:0]    SUM_LIMIT  = 20'(ERR_THRESH * GATE_LEN);
  localparam logic [15:0]    LOCK_N     = 16'(LOCK_LINES);
  localparam logic [15:0]    UNLOCK_N   = 16'(UNLOCK_LINES);
  localparam logic [MW-1:0]  HOLD_N     = MW'(HOLD_LINES);

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------- burst edges
  logic burst_q;
  logic in_burst;   // a rise was seen and the matching fall has not arrived yet
  logic gated;      // the gate already opened during this burst
  logic gate_on;
  logic rise, fall;

  assign rise = burst_active & ~burst_q;
  // A fall without a seen rise (burst already in flight at reset release) is ignored.
  assign fall = ~burst_active & burst_q & in_burst;

  // ---------------------------------------------------------------- |error|
  logic [11:0] err_neg;
  logic [10:0] abs_err;
  assign err_neg = -error_in;
  // Negating -2048 yields -2048 again (bit 11 still set); clamp that case to 2047.
  assign abs_err = error_in[11] ? (err_neg[11] ? 11'h7FF : err_neg[10:0]) : error_in[10:0];

  // ---------------------------------------------------------------- gate and accumulator
  logic [GDW-1:0] guard_cnt;
  logic [GTW-1:0] gate_cnt, gate_cnt_nxt;
  logic [19:0]    sum_acc, sum_nxt;
  logic [20:0]    sum_wide;
  logic           gate_open, gate_close;

  assign sum_wide     = {1'b0, sum_acc} + {10'd0, abs_err};
  // Next values include the current cycle's sample so the fall-cycle capture is complete.
  assign gate_cnt_nxt = gate_on ? gate_cnt + GTW'(1) : gate_cnt;
  assign sum_nxt      = gate_on ? (sum_wide[20] ? 20'hFFFFF : sum_wide[19:0]) : sum_acc;
  assign gate_open    = in_burst & ~fall & ~gated & (guard_cnt == GUARD_LAST);
  assign gate_close   = gate_on & (fall | (gate_cnt_nxt == GATE_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Reset high so a burst already in flight at release does not look like a rise.
      burst_q   <= 1'b1;
      in_burst  <= 1'b0;
      gated     <= 1'b0;
      gate_on   <= 1'b0;
      guard_cnt <= '0;
      gate_cnt  <= '0;
      sum_acc   <= '0;
    end else begin
      burst_q <= burst_active;
      if (rise) begin
        // The rise cycle itself is the first cycle of the guard interval.
        in_burst  <= 1'b1;
        gated     <= 1'b0;
        gate_on   <= 1'b0;
        guard_cnt <= GDW'(1);
        gate_cnt  <= '0;
        sum_acc   <= '0;
      end else begin
        if (fall)
          in_burst <= 1'b0;
        if (in_burst && !gated && guard_cnt != GUARD_LAST)
          guard_cnt <= guard_cnt + GDW'(1);
        if (gate_open) begin
          gate_on <= 1'b1;
          gated   <= 1'b1;
        end else if (gate_close) begin
          gate_on <= 1'b0;
        end
        gate_cnt <= gate_cnt_nxt;
        sum_acc  <= sum_nxt;
      end
    end
  end

  // ---------------------------------------------------------------- two-stage evaluation
  logic        eval_vld;
  logic        eval_full;
  logic [19:0] eval_sum;
  logic        burst_good, burst_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eval_vld  <= 1'b0;
      eval_full <= 1'b0;
      eval_sum  <= '0;
    end else begin
      eval_vld <= fall;
      if (fall) begin
        eval_full <= (gate_cnt_nxt == GATE_LAST);
        eval_sum  <= sum_nxt;
      end
    end
  end

  assign burst_good = eval_vld & eval_full & (eval_sum <= SUM_LIMIT);
  assign burst_bad  = eval_vld & ~burst_good;

  // ---------------------------------------------------------------- line watchdog
  logic [WDW-1:0] wd_cnt;
  logic           wd_hit, missing;

  assign wd_hit  = (wd_cnt == WD_LAST);
  // A timeout that collides with a fall or its evaluation is dropped; the burst verdict wins.
  assign missing = wd_hit & ~rise & ~fall & ~eval_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wd_cnt <= '0;
    else if (rise || wd_hit)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WDW'(1);
  end

  // ---------------------------------------------------------------- lock FSM
  state_t        state, state_nxt;
  logic [15:0]   good_cnt, good_nxt;
  logic [15:0]   bad_cnt, bad_nxt;
  logic [MW-1:0] miss_cnt, miss_nxt;
  logic          enter_search;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_SEARCH;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      miss_cnt   <= '0;
      loop_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      miss_cnt   <= miss_nxt;
      loop_reset <= enter_search;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_nxt     = good_cnt;
    bad_nxt      = bad_cnt;
    miss_nxt     = miss_cnt;
    enter_search = 1'b0;

    if (burst_good) begin
      good_nxt = sat_inc(good_cnt);
      bad_nxt  = '0;
    end else if (burst_bad) begin
      bad_nxt  = sat_inc(bad_cnt);
      good_nxt = '0;
    end

    case (state)
      ST_SEARCH: begin
        if (burst_good)
          state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (burst_good && good_nxt >= LOCK_N)
          state_nxt = ST_LOCKED;
        else if ((burst_bad && bad_nxt >= UNLOCK_N) || missing)
          state_nxt = ST_SEARCH;
      end
      ST_LOCKED: begin
        if (burst_bad && bad_nxt >= UNLOCK_N) begin
          state_nxt = ST_SEARCH;
        end else if (missing) begin
          // The burst that triggered HOLDOVER counts as the first missing one.
          state_nxt = ST_HOLDOVER;
          miss_nxt  = MW'(1);
        end
      end
      ST_HOLDOVER: begin
        if (burst_good) begin
          state_nxt = ST_LOCKED;
        end else if (burst_bad) begin
          state_nxt = ST_SEARCH;
        end else if (missing) begin
          miss_nxt = miss_cnt + MW'(1);
          if (miss_nxt >= HOLD_N)
            state_nxt = ST_SEARCH;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase

    if (state_nxt != ST_HOLDOVER)
      miss_nxt = '0;

    // Run-length counters restart from zero whenever the lock is abandoned.
    enter_search = (state_nxt == ST_SEARCH) && (state != ST_SEARCH);
    if (enter_search) begin
      good_nxt = '0;
      bad_nxt  = '0;
      miss_nxt = '0;
    end
  end

  // ---------------------------------------------------------------- outputs
  // The gate keeps running in HOLDOVER so bursts can still be graded; only the output is masked.
  assign loop_enable = gate_on & (state != ST_HOLDOVER);
  assign locked      = (state == ST_LOCKED);
  assign color_kill  = ~state[1];
  assign lock_state  = state;

`ifdef CHROMA_LOCK_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_bursts  <= '0;
      bad_bursts   <= '0;
      last_err_sum <= '0;
    end else begin
      if (burst_good)
        good_bursts <= sat_inc(good_bursts);
      if (burst_bad)
        bad_bursts <= sat_inc(bad_bursts);
      if (eval_vld)
        last_err_sum <= eval_sum;
    end
  end
`endif

endmodule

// File: tb/tb_chroma_lock_controller.sv
// tb_chroma_lock_controller: drives whole video lines (burst then idle) into the lock controller.
// Each line is graded by a per-line reference model built from the lock rules.
// Outputs are sampled on the falling clock edge.
module tb_chroma_lock_controller;

  localparam int GUARD_START  = 16;
  localparam int GATE_LEN     = 128;
  localparam int ERR_THRESH   = 256;
  localparam int LOCK_LINES   = 16;
  localparam int UNLOCK_LINES = 4;
  localparam int LINE_TIMEOUT = 2000;
  localparam int HOLD_LINES   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              burst_active = 1'b0;
  logic signed [11:0] error_in = '0;
  logic              loop_enable, loop_reset, locked, color_kill;
  logic [1:0]        lock_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock state (0..3) and run lengths, stepped once per verdict or missing line.
  int m_state   = 0;
  int m_good    = 0;
  int m_bad     = 0;
  int m_miss    = 0;
  int m_entries = 0;

  always #5 clk = ~clk;

  chroma_lock_controller #(
    .GUARD_START (GUARD_START),
    .GATE_LEN    (GATE_LEN),
    .ERR_THRESH  (ERR_THRESH),
    .LOCK_LINES  (LOCK_LINES),
    .UNLOCK_LINES(UNLOCK_LINES),
    .LINE_TIMEOUT(LINE_TIMEOUT),
    .HOLD_LINES  (HOLD_LINES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .burst_active(burst_active),
    .error_in    (error_in),
    .loop_enable (loop_enable),
    .loop_reset  (loop_reset),
    .locked      (locked),
    .color_kill  (color_kill),
    .lock_state  (lock_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_miss = 0;
  endtask

  task automatic model_search();
    m_state = 0; m_good = 0; m_bad = 0; m_miss = 0;
    m_entries++;
  endtask

  task automatic model_verdict(input bit good);
    if (good) begin
      m_good = (m_good < 65535) ? m_good + 1 : m_good;
      m_bad  = 0;
    end else begin
      m_bad  = (m_bad < 65535) ? m_bad + 1 : m_bad;
      m_good = 0;
    end
    if (m_state == 0) begin
      if (good) m_state = 1;
    end else if (m_state == 1) begin
      if (good && m_good >= LOCK_LINES) m_state = 2;
      else if (!good && m_bad >= UNLOCK_LINES) model_search();
    end else if (m_state == 2) begin
      if (!good && m_bad >= UNLOCK_LINES) model_search();
    end else begin
      if (good) begin m_state = 2; m_miss = 0; end
      else model_search();
    end
  endtask

  task automatic model_missing();
    if (m_state == 1) begin
      model_search();
    end else if (m_state == 2) begin
      m_state = 3; m_miss = 1;
    end else if (m_state == 3) begin
      m_miss++;
      if (m_miss >= HOLD_LINES) model_search();
    end
  endtask

  // One line: burst high for len cycles from k=0, idle until the next line at k=period.
  // mode 0 drives the constant amp; mode 1 drives uniform random in [-amp, amp].
  task automatic run_line(input int len, input int period, input int mode, input int amp);
    int  sum, win_hi, le_cnt, le_first, lr_cnt, pre_state, entries0, exp_le, e, a;
    bit  good;
    pre_state = m_state;
    entries0  = m_entries;
    sum = 0; le_cnt = 0; le_first = -1; lr_cnt = 0;
    win_hi = (len < GUARD_START + GATE_LEN) ? len : GUARD_START + GATE_LEN;
    exp_le = (pre_state == 3 || len <= GUARD_START) ? 0 : win_hi - GUARD_START;
    for (int k = 0; k < period; k++) begin
      burst_active = (k < len);
      if (mode == 0) e = amp;
      else e = int'($urandom_range(2 * amp)) - amp;
      error_in = 12'(e);
      // The gated window spans cycles GUARD_START+1 .. GUARD_START+GATE_LEN, cut short by the fall.
      if (k >= GUARD_START + 1 && k <= win_hi) begin
        a = (e < 0) ? -e : e;
        if (a > 2047) a = 2047;
        sum += a;
      end
      @(negedge clk);
      if (loop_enable) begin
        le_cnt++;
        if (le_first < 0) le_first = k;
      end
      if (loop_reset) lr_cnt++;
      if (k == 0) chk("state_at_rise", lock_state, pre_state);
      if (k == len + 1) begin
        chk("state_in_eval_cycle", lock_state, pre_state);
        good = (len >= GUARD_START + GATE_LEN) && (sum <= ERR_THRESH * GATE_LEN);
        model_verdict(good);
      end
      if (k == len + 2) chk("state_after_eval", lock_state, m_state);
      if (k > 0 && (k % LINE_TIMEOUT) == 0) model_missing();
      if (k == period - 1) begin
        chk("state_end_of_line", lock_state, m_state);
        chk("locked_end_of_line", locked, (m_state == 2));
        chk("color_kill_end_of_line", color_kill, (m_state < 2));
      end
      @(posedge clk); #1;
    end
    chk("loop_enable_cycles", le_cnt, exp_le);
    if (exp_le > 0) chk("loop_enable_first_cycle", le_first, GUARD_START + 1);
    chk("loop_reset_cycles", lr_cnt, m_entries - entries0);
  endtask

  // Line in LOCKED with a one-cycle asynchronous reset in the middle of the gate.
  task automatic reset_mid_line();
    int le_after, lr_cnt;
    le_after = 0; lr_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      burst_active = (k < 200);
      error_in = 12'sd100;
      @(negedge clk);
      if (k > 60 && loop_enable) le_after++;
      if (loop_reset) lr_cnt++;
      if (k == 60) begin
        chk("gate_open_before_reset", loop_enable, (m_state == 2));
        chk("locked_before_reset", locked, (m_state == 2));
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_lock_state", lock_state, m_state);
        chk("arst_locked", locked, 0);
        chk("arst_color_kill", color_kill, 1);
        chk("arst_loop_enable", loop_enable, 0);
        chk("arst_loop_reset", loop_reset, 0);
        @(negedge clk);
        rst = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("no_gate_for_inflight_burst", le_after, 0);
    chk("no_loop_reset_after_arst", lr_cnt, 0);
    chk("state_after_inflight_burst", lock_state, m_state);
  endtask

  initial begin
    int lens[4];
    int amps[3];
    lens = '{100, 160, 200, 250};
    amps = '{150, 300, 600};

    // Reset values while held in reset.
    #12;
    chk("reset_lock_state", lock_state, 0);
    chk("reset_locked", locked, 0);
    chk("reset_color_kill", color_kill, 1);
    chk("reset_loop_enable", loop_enable, 0);
    chk("reset_loop_reset", loop_reset, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("no_loop_reset_after_release", loop_reset, 0);
    @(posedge clk); #1;

    // 20 good bursts: ACQUIRE after the first, LOCKED after the 16th.
    for (int i = 0; i < 20; i++) run_line(200, 300, 0, 100);
    // Four bad bursts drop lock.
    for (int i = 0; i < 4; i++) run_line(200, 300, 0, 400);
    // Relock on random low-error bursts.
    for (int i = 0; i < 16; i++) run_line(200, 300, 1, 300);
    // Three missing lines -> HOLDOVER, then a good burst -> LOCKED.
    run_line(200, 3 * LINE_TIMEOUT + 300, 0, 100);
    run_line(200, 300, 0, 100);
    // Eight missing lines -> SEARCH.
    run_line(200, HOLD_LINES * LINE_TIMEOUT + 300, 0, 100);
    // Short bursts with zero error never grade as good.
    for (int i = 0; i < 6; i++) run_line(100, 300, 0, 0);
    // Relock, then full-gate -2048 bursts (saturated magnitude) drop lock.
    for (int i = 0; i < 16; i++) run_line(200, 300, 0, 100);
    for (int i = 0; i < 4; i++) run_line(200, 300, 0, -2048);
    // Relock, reset mid-gate, then 16 fresh good bursts are needed.
    for (int i = 0; i < 16; i++) run_line(200, 300, 1, 150);
    reset_mid_line();
    for (int i = 0; i < 16; i++) run_line(200, 300, 0, 100);
    // Random mix of lengths and error levels.
    for (int i = 0; i < 20; i++)
      run_line(lens[$urandom_range(3)], 300, 1, amps[$urandom_range(2)]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
